mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported backing memory between the core's instruction-fetch requester and its load/store requester. It sits between the datapath/controlpath request signals and the memory bus. It serialises accesses through a small FSM, returns read data in holding registers, and drives the per-requester `wait_instr`/`wait_data` stall signals consumed by the control path. A cycle-count timeout converts a hung memory access into a bus-error pulse so the core never deadlocks.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 255: maximum cycles spent in a BUSY state before abort. Must be ≥1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `instr_req`  in  1  instruction fetch requested.
- `instr_addr`  in  AW  fetch address.
- `instr`  out  DW  last fetched word (registered).
- `wait_instr`  out  1  fetch stall.
- `data_rd`  in  1  load requested.
- `data_wr`  in  1  store requested.
- `data_addr`  in  AW  load/store address.
- `data_in`  in  DW  store data.
- `data`  out  DW  last loaded word (registered).
- `wait_data`  out  1  load/store stall.
- `mem_req`  out  1  memory access active.
- `mem_we`  out  1  access is a write.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  memory completion, one-cycle pulse.
- `bus_err`  out  1  one-cycle pulse on timeout.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D. Reset state is IDLE.
- IDLE transitions:
  - Pending data (`data_rd|data_wr`) with no fetch → BUSY_D.
  - Fetch only → BUSY_I.
  - Neither → stay in IDLE.
  - Both pending → tie-break (see Configuration).
- On entering BUSY_x: latch address, write data and `mem_we` into the `mem_*` registers, and set `mem_req`=1.
  - `mem_we` = `data_wr` for data accesses, 0 for fetches.
  - If `data_wr` and `data_rd` are both high, it is a write; the read is ignored.
- BUSY_x with `mem_ack`=1 → RESP_x.
  - Read: capture `mem_rdata` into `instr` (BUSY_I) or `data` (BUSY_D).
  - Write: `data` is unchanged.
  - Clear `mem_req`/`mem_we`.
- BUSY_x timeout: `TIMEOUT` consecutive cycles with no ack → RESP_x.
  - Drop `mem_req`, pulse `bus_err` for one cycle, load 0 into the target read register (writes: register unchanged).
  - The timeout counter is cleared on every BUSY entry.
- RESP_x → IDLE unconditionally after one cycle.
- Stall signals (combinational):
  - `wait_instr` = `instr_req` & (state≠RESP_I).
  - `wait_data` = (`data_rd`|`data_wr`) & (state≠RESP_D).
- Requesters hold request, address and data stable until their wait signal is low.
- A request withdrawn while BUSY: the access completes on the bus and the result is still captured. Stall behaviour is undefined for that requester.
- `mem_ack` in any non-BUSY state is ignored.
- `instr` and `data` hold their values until the next completing read for that requester.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `bus_err` = 0.
  - `mem_addr`, `mem_wdata`, `instr`, `data` = 0.
  - Timeout counter = 0. `last_grant` = INSTR.
- During reset, the wait outputs follow their requests (state IDLE).
- Reset mid-transaction: `mem_req` drops at the next edge and any later `mem_ack` is ignored.
- Minimum latency, with the request visible in cycle 0:
  - Cycle 1: `mem_req` high.
  - Ack arrives in cycle 1 → cycle 2 is RESP_x with wait low and read data valid.
- Each access costs ≥3 cycles; back-to-back grants are separated by one IDLE cycle.
- Timeout: `bus_err` is high in the cycle the FSM is in RESP_x. `mem_req` was high for exactly `TIMEOUT` cycles.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: ties in IDLE go to the requester not in `last_grant`; `last_grant` updates on every grant. From reset, the first tie goes to data.
  - Undefined: data always wins ties (fixed priority); the `last_grant` register is not built.

## Test plan
- **Fetch:** `instr_req`=1, `instr_addr`=0x100, memory acks 1 cycle after `mem_req` with 0xDEADBEEF. Required: `mem_addr`=0x100, `mem_we`=0; `wait_instr` low for exactly one cycle; `instr`=0xDEADBEEF.
- **Store:** `data_wr`=1, `data_addr`=0x40, `data_in`=0x12345678. Required: `mem_we`=1, `mem_wdata`=0x12345678; `data` register unchanged; `wait_data` drops once.
- **Contention:** `instr_req` and `data_rd` held together for 4 grants.
  - With `MEM_ARB_ROUND_ROBIN_EN`: order D,I,D,I.
  - Without it: data is served first; fetch is served only after `data_rd` is released.
- **Timeout:** `TIMEOUT`=4, memory never acks a load. Required: `mem_req` high 4 cycles, then `bus_err` pulses once, `data`=0, `wait_data` low one cycle.
- **Reset mid-access:** `reset` asserted while in BUSY_D, late `mem_ack` after reset. Required: `mem_req`=0 next edge, FSM in IDLE, `data` stays 0, no `bus_err`.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/stall signals and memory-bus signals of mem_port_arbiter.
// The arbiter takes the master view; the environment (core + memory) takes the slave view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr;
  logic          wait_instr;

  logic          data_rd;
  logic          data_wr;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data;
  logic          wait_data;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          bus_err;

  modport master (
    input  instr_req, instr_addr, data_rd, data_wr, data_addr, data_in, mem_rdata, mem_ack,
    output instr, wait_instr, data, wait_data, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport slave (
    output instr_req, instr_addr, data_rd, data_wr, data_addr, data_in, mem_rdata, mem_ack,
    input  instr, wait_instr, data, wait_data, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-ported memory bus,
// with a per-access timeout. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned   CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StRespI,
    StRespD
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] tmo_cnt_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [DW-1:0]   instr_q;
  logic [DW-1:0]   data_q;
  logic            bus_err_q;

  logic data_pend;
  logic data_wins;
  logic grant_i;
  logic grant_d;
  logic acked;
  logic timed_out;
  logic busy;

  assign data_pend = bus.data_rd | bus.data_wr;
  assign busy      = (state_q == StBusyI) || (state_q == StBusyD);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;  // 1: most recent grant went to instruction fetch

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (grant_i || grant_d) begin
      last_grant_q <= grant_i;
    end
  end

  assign data_wins = last_grant_q;
`else
  assign data_wins = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_pend && (!bus.instr_req || data_wins)) begin
          grant_d = 1'b1;
          state_d = StBusyD;
        end else if (bus.instr_req) begin
          grant_i = 1'b1;
          state_d = StBusyI;
        end
      end
      StBusyI, StBusyD: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        if (bus.mem_ack) begin
          acked = 1'b1;
        end else if (tmo_cnt_q == CntLast) begin
          timed_out = 1'b1;
        end
        if (acked || timed_out) begin
          state_d = (state_q == StBusyI) ? StRespI : StRespD;
        end
      end
      StRespI, StRespD: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      data_q      <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= timed_out;
      if (grant_i || grant_d) begin
        tmo_cnt_q  <= '0;
        mem_req_q  <= 1'b1;
        mem_we_q   <= grant_d & bus.data_wr;
        mem_addr_q <= grant_d ? bus.data_addr : bus.instr_addr;
        if (grant_d) begin
          mem_wdata_q <= bus.data_in;
        end
      end else if (acked || timed_out) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        // Writes leave both read registers alone; a timed-out read loads zero.
        if (!mem_we_q) begin
          if (state_q == StBusyI) begin
            instr_q <= acked ? bus.mem_rdata : '0;
          end else begin
            data_q <= acked ? bus.mem_rdata : '0;
          end
        end
      end else if (busy) begin
        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.instr     = instr_q;
  assign bus.data      = data_q;
  assign bus.bus_err   = bus_err_q;

  // While reset is held the FSM is treated as IDLE, so stalls simply follow requests.
  assign bus.wait_instr = bus.instr_req & (reset | (state_q != StRespI));
  assign bus.wait_data  = data_pend & (reset | (state_q != StRespD));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle comparison against a transaction-level
// model plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int unsigned Tmo = 4;
  localparam int NONE = 0;
  localparam int INS  = 1;
  localparam int DAT  = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(Tmo)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory responder: acks ack_lat cycles after mem_req rises, data = rdata_val ^ address.
  bit          ack_en    = 1'b1;
  int          ack_lat   = 0;
  bit          force_ack = 1'b0;
  logic [31:0] rdata_val = '0;
  int          rsp_age   = 0;
  bit          rsp_prev  = 1'b0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) rsp_age = rsp_prev ? rsp_age + 1 : 0;
      else rsp_age = 0;
      rsp_prev      = bus.mem_req;
      bus.mem_ack   = force_ack || (ack_en && bus.mem_req && rsp_age == ack_lat);
      bus.mem_rdata = rdata_val ^ bus.mem_addr;
    end
  end

  // Reference model: who owns the bus, how long it has waited, who is being answered.
  int          m_busy, m_resp, m_cycles, m_last, m_pick;
  logic        m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_instr, m_data;

  function automatic int winner(input bit want_i, input bit want_d, input int last);
    if (want_i && want_d) return (RoundRobin && last == DAT) ? INS : DAT;
    if (want_d) return DAT;
    if (want_i) return INS;
    return NONE;
  endfunction

  always_comb m_pick = winner(bus.instr_req, bus.data_rd | bus.data_wr, m_last);

  always @(posedge clk) begin
    m_err <= 1'b0;
    if (reset) begin
      m_busy <= NONE; m_resp <= NONE; m_cycles <= 0; m_last <= INS;
      m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_instr <= '0; m_data <= '0;
    end else if (m_resp != NONE) begin
      m_resp <= NONE;
    end else if (m_busy == NONE) begin
      if (m_pick != NONE) begin
        m_busy   <= m_pick;
        m_cycles <= 1;
        m_last   <= m_pick;
        m_we     <= (m_pick == DAT) && bus.data_wr;
        m_addr   <= (m_pick == DAT) ? bus.data_addr : bus.instr_addr;
        if (m_pick == DAT) m_wdata <= bus.data_in;
      end
    end else if (bus.mem_ack || m_cycles == Tmo) begin
      m_busy <= NONE;
      m_resp <= m_busy;
      m_we   <= 1'b0;
      m_err  <= !bus.mem_ack;
      if (!m_we) begin
        if (m_busy == INS) m_instr <= bus.mem_ack ? bus.mem_rdata : 32'h0;
        else m_data <= bus.mem_ack ? bus.mem_rdata : 32'h0;
      end
    end else begin
      m_cycles <= m_cycles + 1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #4;
      if (chk_en) begin
        chk("mem_req", bus.mem_req, m_busy != NONE);
        chk("mem_we", bus.mem_we, m_we);
        chk("bus_err", bus.bus_err, m_err);
        chk("instr", bus.instr, m_instr);
        chk("data", bus.data, m_data);
        chk("wait_instr", bus.wait_instr, bus.instr_req && (reset || m_resp != INS));
        chk("wait_data", bus.wait_data, (bus.data_rd || bus.data_wr) && (reset || m_resp != DAT));
        if (m_busy != NONE) begin
          chk("mem_addr", bus.mem_addr, m_addr);
          if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  // Results of one directed access.
  int          r_lat, r_req, r_err;
  logic        r_back, r_we;
  logic [31:0] r_addr, r_wdata;

  task automatic run_access(input bit is_i, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    r_lat = -1; r_req = 0; r_err = 0; r_back = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
    if (is_i) begin
      bus.instr_req = 1'b1; bus.instr_addr = addr;
    end else begin
      bus.data_rd = rd; bus.data_wr = wr; bus.data_addr = addr; bus.data_in = wd;
    end
    for (int c = 1; c <= 20 && r_lat < 0; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (!got) begin
          r_addr = bus.mem_addr; r_we = bus.mem_we; r_wdata = bus.mem_wdata; got = 1'b1;
        end
        r_req++;
      end
      if (bus.bus_err) r_err++;
      if (is_i ? !bus.wait_instr : !bus.wait_data) r_lat = c;
    end
    // Keep the request one more cycle: the stall must come back after a single low cycle.
    @(negedge clk);
    r_back = is_i ? bus.wait_instr : bus.wait_data;
    if (bus.bus_err) r_err++;
    if (bus.mem_req) r_req++;
    bus.instr_req = 1'b0; bus.data_rd = 1'b0; bus.data_wr = 1'b0;
    @(negedge clk);
  endtask

  int          d_left, grants;
  bit          c_prev;
  logic [7:0]  order;

  initial begin
    reset = 1'b1;
    bus.instr_req = 1'b0; bus.instr_addr = '0;
    bus.data_rd = 1'b0; bus.data_wr = 1'b0; bus.data_addr = '0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_bus_err", bus.bus_err, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_data", bus.data, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch, minimum latency.
    rdata_val = 32'hDEADBEEF ^ 32'h100; ack_lat = 0;
    run_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    chk("fetch_lat", r_lat, 2);
    chk("fetch_req_cycles", r_req, 1);
    chk("fetch_addr", r_addr, 32'h100);
    chk("fetch_we", r_we, 1'b0);
    chk("fetch_wait_back", r_back, 1'b1);
    chk("fetch_instr", bus.instr, 32'hDEADBEEF);

    // Load.
    rdata_val = 32'hCAFEF00D ^ 32'h80;
    run_access(1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
    chk("load_lat", r_lat, 2);
    chk("load_data", bus.data, 32'hCAFEF00D);

    // Store with one wait cycle on the bus.
    ack_lat = 1;
    run_access(1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678);
    chk("store_lat", r_lat, 3);
    chk("store_req_cycles", r_req, 2);
    chk("store_we", r_we, 1'b1);
    chk("store_addr", r_addr, 32'h40);
    chk("store_wdata", r_wdata, 32'h12345678);
    chk("store_wait_back", r_back, 1'b1);
    chk("store_data_kept", bus.data, 32'hCAFEF00D);

    // Read and write together is a write.
    ack_lat = 0;
    run_access(1'b0, 1'b1, 1'b1, 32'h44, 32'h0BADF00D);
    chk("rdwr_we", r_we, 1'b1);
    chk("rdwr_data_kept", bus.data, 32'hCAFEF00D);

    // Contention: data requester does three loads, fetch stays pending throughout.
    rdata_val = 32'h0; bus.instr_addr = 32'h200; bus.data_addr = 32'h300;
    bus.instr_req = 1'b1; bus.data_rd = 1'b1;
    d_left = 3; grants = 0; c_prev = 1'b0; order = '0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      @(negedge clk);
      if (bus.mem_req && !c_prev) begin
        order = {order[5:0], (bus.mem_addr == 32'h300) ? 2'(DAT) : 2'(INS)};
        grants++;
      end
      c_prev = bus.mem_req;
      if (!bus.wait_data && bus.data_rd) begin
        d_left--;
        if (d_left == 0) bus.data_rd = 1'b0;
      end
    end
    bus.instr_req = 1'b0; bus.data_rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("contention_grants", grants, 4);
    chk("contention_order", order, RoundRobin ? 8'h99 : 8'hA9);

    // Timeout on a load that is never acked.
    ack_en = 1'b0;
    run_access(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
    chk("tmo_lat", r_lat, 5);
    chk("tmo_req_cycles", r_req, 4);
    chk("tmo_bus_err_pulses", r_err, 1);
    chk("tmo_wait_back", r_back, 1'b1);
    chk("tmo_data", bus.data, 32'h0);

    // Reset in the middle of a load, then a stray ack.
    rdata_val = 32'h55AA55AA;
    bus.data_rd = 1'b1; bus.data_addr = 32'h600;
    @(negedge clk);
    chk("rstmid_busy", bus.mem_req, 1'b1);
    reset = 1'b1; bus.data_rd = 1'b0;
    @(negedge clk);
    chk("rstmid_req_drop", bus.mem_req, 1'b0);
    reset = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid_no_err", bus.bus_err, 1'b0);
      chk("rstmid_idle", bus.mem_req, 1'b0);
      chk("rstmid_data", bus.data, 32'h0);
    end
    ack_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
